// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states,
// and the small arithmetic helpers used by the top and the divider.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_DIV   = 4'd1,
        OP_DIVU  = 4'd2,
        OP_MUL   = 4'd3,
        OP_MULT  = 4'd4,
        OP_MULTU = 4'd5,
        OP_MFHI  = 4'd6,
        OP_MFLO  = 4'd7,
        OP_MTHI  = 4'd8,
        OP_MTLO  = 4'd9
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DIV_RUN = 2'd2,
        ST_GMUL    = 2'd3
    } mdu_state_e;

    localparam int DIV_ITERS = 32;

    // Codes 10..15 are deliberately treated like "no op".
    function automatic logic is_mdu_op(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd9);
    endfunction

    // Two's-complement negate when n is set.
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
        return n ? (32'd0 - v) : v;
    endfunction

    // One restoring-division step: returns {remainder, quotient/dividend shift}.
    // The partial remainder is always below the divisor, so 33 bits cover the shift.
    function automatic logic [63:0] div_step(input logic [31:0] rem,
                                             input logic [31:0] quo,
                                             input logic [31:0] dvs);
        logic [32:0] shifted;
        logic [32:0] diff;
        shifted = {rem, quo[31]};
        diff    = shifted - {1'b0, dvs};
        if (!diff[32]) begin
            return {diff[31:0], quo[30:0], 1'b1};
        end else begin
            return {shifted[31:0], quo[30:0], 1'b0};
        end
    endfunction

endpackage

// File: rtl/mdu_div.sv
// Iterative 32-bit restoring divider working on magnitudes.
// The start edge performs the first iteration, the next 31 edges the rest,
// and the cycle after that is the sign-fixup cycle in which done_o is high
// and quot_o/rem_o carry the final signed results.
module mdu_div
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        done_o,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);

    logic        run_q;
    logic [5:0]  cnt_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic        qneg_q;
    logic        rneg_q;
    logic        dz_q;

    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [63:0] first_s;
    logic [63:0] next_s;

    // Operand magnitudes and the combinational iteration step.
    always_comb begin
        a_neg_s = signed_i & a_i[31];
        b_neg_s = signed_i & b_i[31];
        a_mag_s = neg_if(a_i, a_neg_s);
        b_mag_s = neg_if(b_i, b_neg_s);
        first_s = div_step(32'd0, a_mag_s, b_mag_s);
        next_s  = div_step(rem_q, quo_q, dvs_q);
    end

    // Iteration state: load on start, step until all quotient bits are formed.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q  <= 1'b0;
            cnt_q  <= 6'd0;
            rem_q  <= 32'd0;
            quo_q  <= 32'd0;
            dvs_q  <= 32'd0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
        end else if (start_i) begin
            run_q          <= 1'b1;
            cnt_q          <= 6'd1;
            {rem_q, quo_q} <= first_s;
            dvs_q          <= b_mag_s;
            qneg_q         <= a_neg_s ^ b_neg_s;
            rneg_q         <= a_neg_s;
            dz_q           <= (b_i == 32'd0);
        end else if (run_q) begin
            if (cnt_q == 6'(DIV_ITERS)) begin
                run_q <= 1'b0;
            end else begin
                {rem_q, quo_q} <= next_s;
                cnt_q          <= cnt_q + 6'd1;
            end
        end else begin
            run_q <= 1'b0;
        end
    end

    // Sign fixup: quotient truncates toward zero, remainder follows the dividend.
    // Divide by zero reports an all-ones quotient and the dividend as remainder.
    always_comb begin
        done_o = run_q && (cnt_q == 6'(DIV_ITERS));
        if (dz_q) begin
            quot_o = 32'hFFFF_FFFF;
        end else begin
            quot_o = neg_if(quo_q, qneg_q);
        end
        rem_o = neg_if(rem_q, rneg_q);
    end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit in EX. Owns HI/LO, runs MULT/MULTU/DIV/DIVU in the
// background, runs MUL as a blocking op, and stalls the pipeline on
// structural or HI/LO data hazards.
module mdu
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdu_valid_i,
    input  logic [3:0]  mdu_op_i,
    input  logic [31:0] mdu_a_i,
    input  logic [31:0] mdu_b_i,
    input  logic        mdu_flush_i,
    output logic [31:0] mdu_result_o,
    output logic        mdu_stall_o,
    output logic        mdu_busy_o
);

    mdu_state_e  state_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [63:0] prod_q;
    logic [7:0]  cnt_q;

    mdu_op_e     op_s;
    logic        live_s;
    logic        busy_s;
    logic        mul_done_s;
    logic        stall_s;
    logic        accept_s;
    logic        div_start_s;
    logic        div_signed_s;
    logic        div_done_s;
    logic [63:0] prod_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

    // Hazard detection, acceptance and the behavioural multiplier.
    always_comb begin
        op_s         = mdu_op_e'(mdu_op_i);
        live_s       = mdu_valid_i && !mdu_flush_i && is_mdu_op(mdu_op_i);
        busy_s       = (state_q == ST_MUL_RUN) || (state_q == ST_DIV_RUN);
        mul_done_s   = (state_q == ST_GMUL) && (cnt_q == 8'd0);
        stall_s      = live_s && (busy_s || ((op_s == OP_MUL) && !mul_done_s));
        accept_s     = live_s && !stall_s;
        div_signed_s = (op_s == OP_DIV);
        div_start_s  = accept_s && (state_q == ST_IDLE) &&
                       ((op_s == OP_DIV) || (op_s == OP_DIVU));
        if (op_s == OP_MULTU) begin
            prod_s = {32'd0, mdu_a_i} * {32'd0, mdu_b_i};
        end else begin
            prod_s = 64'($signed(mdu_a_i)) * 64'($signed(mdu_b_i));
        end
    end

    mdu_div u_div (
        .clk      (clk),
        .rst      (rst),
        .start_i  (div_start_s),
        .signed_i (div_signed_s),
        .a_i      (mdu_a_i),
        .b_i      (mdu_b_i),
        .done_o   (div_done_s),
        .quot_o   (quot_s),
        .rem_o    (rem_s)
    );

    // Control FSM plus HI/LO and multiplier delay-line state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            prod_q  <= 64'd0;
            cnt_q   <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mdu_valid_i && !mdu_flush_i && (op_s == OP_MUL)) begin
                        // Blocking MUL: hold the pipeline for MUL_LAT cycles.
                        state_q <= ST_GMUL;
                        prod_q  <= prod_s;
                        cnt_q   <= 8'(MUL_LAT - 1);
                    end else if (accept_s) begin
                        case (op_s)
                            OP_DIV, OP_DIVU: begin
                                state_q <= ST_DIV_RUN;
                            end
                            OP_MULT, OP_MULTU: begin
                                if (MUL_LAT > 1) begin
                                    state_q <= ST_MUL_RUN;
                                    prod_q  <= prod_s;
                                    cnt_q   <= 8'(MUL_LAT - 2);
                                end else begin
                                    {hi_q, lo_q} <= prod_s;
                                end
                            end
                            OP_MTHI: begin
                                hi_q <= mdu_a_i;
                            end
                            OP_MTLO: begin
                                lo_q <= mdu_a_i;
                            end
                            default: begin
                                state_q <= ST_IDLE;
                            end
                        endcase
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_MUL_RUN: begin
                    if (cnt_q == 8'd0) begin
                        {hi_q, lo_q} <= prod_q;
                        state_q      <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_DIV_RUN: begin
                    if (div_done_s) begin
                        hi_q    <= rem_s;
                        lo_q    <= quot_s;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_DIV_RUN;
                    end
                end
                ST_GMUL: begin
                    // A killed or vanished MUL leaves with no side effects.
                    if (!mdu_valid_i || mdu_flush_i || (cnt_q == 8'd0)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Result mux: MUL product on its release cycle, HI/LO reads when idle.
    always_comb begin
        if (mul_done_s && mdu_valid_i && !mdu_flush_i) begin
            mdu_result_o = prod_q[31:0];
        end else if (mdu_valid_i && !busy_s && (op_s == OP_MFHI)) begin
            mdu_result_o = hi_q;
        end else if (mdu_valid_i && !busy_s && (op_s == OP_MFLO)) begin
            mdu_result_o = lo_q;
        end else begin
            mdu_result_o = 32'd0;
        end
        mdu_stall_o = stall_s;
        mdu_busy_o  = busy_s;
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: a cycle-level reference model checked every
// cycle, plus directed vectors with hand-computed results and stall counts.
module tb_mdu;

    localparam int L = 2;

    localparam logic [3:0] O_NONE  = 4'd0;
    localparam logic [3:0] O_DIV   = 4'd1;
    localparam logic [3:0] O_DIVU  = 4'd2;
    localparam logic [3:0] O_MUL   = 4'd3;
    localparam logic [3:0] O_MULT  = 4'd4;
    localparam logic [3:0] O_MULTU = 4'd5;
    localparam logic [3:0] O_MFHI  = 4'd6;
    localparam logic [3:0] O_MFLO  = 4'd7;
    localparam logic [3:0] O_MTHI  = 4'd8;
    localparam logic [3:0] O_MTLO  = 4'd9;

    logic        clk = 1'b0;
    logic        rst;
    logic        mdu_valid_i;
    logic [3:0]  mdu_op_i;
    logic [31:0] mdu_a_i;
    logic [31:0] mdu_b_i;
    logic        mdu_flush_i;
    logic [31:0] mdu_result_o;
    logic        mdu_stall_o;
    logic        mdu_busy_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mdu #(.MUL_LAT(L)) dut (
        .clk          (clk),
        .rst          (rst),
        .mdu_valid_i  (mdu_valid_i),
        .mdu_op_i     (mdu_op_i),
        .mdu_a_i      (mdu_a_i),
        .mdu_b_i      (mdu_b_i),
        .mdu_flush_i  (mdu_flush_i),
        .mdu_result_o (mdu_result_o),
        .mdu_stall_o  (mdu_stall_o),
        .mdu_busy_o   (mdu_busy_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic: returns {HI, LO}.
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int ia;
        int ib;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            ia = a;
            ib = b;
            q = ia / ib;
            r = ia % ib;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic logic [63:0] ref_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int ia;
        int ib;
        longint sa;
        longint sb;
        longint unsigned ua;
        longint unsigned ub;
        if (sgn) begin
            ia = a;
            ib = b;
            sa = ia;
            sb = ib;
            return sa * sb;
        end else begin
            ua = a;
            ub = b;
            return ua * ub;
        end
    endfunction

    // Reference model: HI/LO, pending background result with cycles left,
    // and how many unblocked cycles the current MUL has been waiting.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] p_hi = 32'd0;
    logic [31:0] p_lo = 32'd0;
    int          m_left = 0;
    int          m_age = 0;
    bit          m_ok = 0;

    initial begin : model
        logic        is_op;
        logic        e_busy;
        logic        e_stall;
        logic [31:0] e_res;
        logic [63:0] pr;
        forever begin
            @(negedge clk);
            is_op   = mdu_valid_i && (mdu_op_i >= 4'd1) && (mdu_op_i <= 4'd9);
            e_busy  = (m_left > 0);
            e_stall = is_op && !mdu_flush_i && (e_busy || (mdu_op_i == O_MUL && m_age < L));
            pr      = ref_mul(1'b1, mdu_a_i, mdu_b_i);
            e_res   = 32'd0;
            if (mdu_valid_i && !mdu_flush_i && mdu_op_i == O_MUL && !e_busy && m_age == L)
                e_res = pr[31:0];
            else if (mdu_valid_i && !e_busy && mdu_op_i == O_MFHI)
                e_res = m_hi;
            else if (mdu_valid_i && !e_busy && mdu_op_i == O_MFLO)
                e_res = m_lo;
            if (m_ok) begin
                chk("model stall", {31'd0, mdu_stall_o}, {31'd0, e_stall});
                chk("model busy", {31'd0, mdu_busy_o}, {31'd0, e_busy});
                chk("model result", mdu_result_o, e_res);
            end
            if (rst) begin
                m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_age = 0; m_ok = 1;
            end else if (m_ok) begin
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_hi = p_hi;
                        m_lo = p_lo;
                    end
                end
                if (mdu_valid_i && !mdu_flush_i && mdu_op_i == O_MUL && !e_busy)
                    m_age = (m_age == L) ? 0 : m_age + 1;
                else
                    m_age = 0;
                if (is_op && !mdu_flush_i && !e_stall) begin
                    case (mdu_op_i)
                        O_DIV, O_DIVU: begin
                            {p_hi, p_lo} = ref_div(mdu_op_i == O_DIV, mdu_a_i, mdu_b_i);
                            m_left = 32;
                        end
                        O_MULT, O_MULTU: begin
                            pr = ref_mul(mdu_op_i == O_MULT, mdu_a_i, mdu_b_i);
                            if (L > 1) begin
                                {p_hi, p_lo} = pr;
                                m_left = L - 1;
                            end else begin
                                {m_hi, m_lo} = pr;
                            end
                        end
                        O_MTHI: m_hi = mdu_a_i;
                        O_MTLO: m_lo = mdu_a_i;
                        default: ;
                    endcase
                end
            end
        end
    end

    // One cycle of raw stimulus; starts and ends 1ns after a rising edge.
    task automatic cyc(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic f);
        mdu_valid_i = v; mdu_op_i = op; mdu_a_i = a; mdu_b_i = b; mdu_flush_i = f;
        @(posedge clk);
        #1;
    endtask

    // Present an op, hold it until it is no longer stalled, check the
    // number of stalled cycles and optionally the result on the release cycle.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_stalls, input logic chk_res,
                         input logic [31:0] exp_res, input string name);
        int n;
        n = 0;
        mdu_valid_i = 1'b1; mdu_op_i = op; mdu_a_i = a; mdu_b_i = b; mdu_flush_i = 1'b0;
        #1;
        while (mdu_stall_o !== 1'b0 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: stall still high after %0d cycles", name, n);
        end
        chk({name, " stalls"}, n, exp_stalls);
        if (chk_res) chk({name, " result"}, mdu_result_o, exp_res);
        @(posedge clk);
        #1;
        mdu_valid_i = 1'b0; mdu_op_i = O_NONE; mdu_flush_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mdu_valid_i = 1'b0; mdu_op_i = O_NONE;
        mdu_a_i = 32'd0; mdu_b_i = 32'd0; mdu_flush_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset busy", {31'd0, mdu_busy_o}, 32'd0);
        chk("reset result", mdu_result_o, 32'd0);
        #1;
        issue(O_MFHI, 32'd0, 32'd0, 0, 1'b1, 32'd0, "reset hi");

        // Blocking MUL leaves HI/LO untouched.
        issue(O_MTHI, 32'h1111_1111, 32'd0, 0, 1'b0, 32'd0, "mthi");
        issue(O_MTLO, 32'h2222_2222, 32'd0, 0, 1'b0, 32'd0, "mtlo");
        issue(O_MUL, 32'h0001_0000, 32'h0001_0000, L, 1'b1, 32'd0, "mul wrap");
        issue(O_MFHI, 32'd0, 32'd0, 0, 1'b1, 32'h1111_1111, "mul hi kept");
        issue(O_MFLO, 32'd0, 32'd0, 0, 1'b1, 32'h2222_2222, "mul lo kept");

        // MULT followed immediately by a read.
        issue(O_MULT, 32'hFFFF_FFFD, 32'd5, 0, 1'b0, 32'd0, "mult");
        issue(O_MFLO, 32'd0, 32'd0, L - 1, 1'b1, 32'hFFFF_FFF1, "mult lo");
        issue(O_MFHI, 32'd0, 32'd0, 0, 1'b1, 32'hFFFF_FFFF, "mult hi");
        issue(O_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 1'b0, 32'd0, "multu");
        issue(O_MFHI, 32'd0, 32'd0, L - 1, 1'b1, 32'h0000_0001, "multu hi");

        // DIVU overlapped with unrelated instructions, read exactly at T+33.
        issue(O_DIVU, 32'd100, 32'd7, 0, 1'b0, 32'd0, "divu");
        for (int i = 0; i < 32; i++) cyc(1'b1, (i < 16) ? O_NONE : 4'd12, 32'd0, 32'd0, 1'b0);
        issue(O_MFLO, 32'd0, 32'd0, 0, 1'b1, 32'd14, "divu lo");
        issue(O_MFHI, 32'd0, 32'd0, 0, 1'b1, 32'd2, "divu hi");

        issue(O_DIV, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 32'd0, "div neg");
        issue(O_MFLO, 32'd0, 32'd0, 32, 1'b1, 32'hFFFF_FFFD, "div neg lo");
        issue(O_MFHI, 32'd0, 32'd0, 0, 1'b1, 32'hFFFF_FFFF, "div neg hi");

        issue(O_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 32'd0, "div ovf");
        issue(O_MFLO, 32'd0, 32'd0, 32, 1'b1, 32'h8000_0000, "div ovf lo");
        issue(O_MFHI, 32'd0, 32'd0, 0, 1'b1, 32'd0, "div ovf hi");

        issue(O_DIVU, 32'h1234_5678, 32'd0, 0, 1'b0, 32'd0, "divu zero");
        issue(O_MFLO, 32'd0, 32'd0, 32, 1'b1, 32'hFFFF_FFFF, "divu zero lo");
        issue(O_MFHI, 32'd0, 32'd0, 0, 1'b1, 32'h1234_5678, "divu zero hi");

        // MUL behind a running divide waits for idle, then its own latency.
        issue(O_DIVU, 32'd50, 32'd3, 0, 1'b0, 32'd0, "divu2");
        issue(O_MUL, 32'd7, 32'd6, 32 + L, 1'b1, 32'd42, "mul busy");
        issue(O_MFLO, 32'd0, 32'd0, 0, 1'b1, 32'd16, "divu2 lo");

        // MUL killed during its first GMUL cycle.
        issue(O_MTHI, 32'hAAAA_5555, 32'd0, 0, 1'b0, 32'd0, "mthi2");
        issue(O_MTLO, 32'h5555_AAAA, 32'd0, 0, 1'b0, 32'd0, "mtlo2");
        cyc(1'b1, O_MUL, 32'd3, 32'd4, 1'b0);
        cyc(1'b1, O_MUL, 32'd3, 32'd4, 1'b1);
        cyc(1'b0, O_NONE, 32'd0, 32'd0, 1'b0);
        issue(O_MFHI, 32'd0, 32'd0, 0, 1'b1, 32'hAAAA_5555, "flush hi");
        issue(O_MFLO, 32'd0, 32'd0, 0, 1'b1, 32'h5555_AAAA, "flush lo");

        // MTLO behind a running signed divide.
        issue(O_DIV, 32'd100, 32'hFFFF_FFF7, 0, 1'b0, 32'd0, "div3");
        issue(O_MTLO, 32'hCAFE_0001, 32'd0, 32, 1'b0, 32'd0, "mtlo busy");
        issue(O_MFLO, 32'd0, 32'd0, 0, 1'b1, 32'hCAFE_0001, "mtlo busy lo");
        issue(O_MFHI, 32'd0, 32'd0, 0, 1'b1, 32'd1, "div3 hi");

        // Reset in the middle of a divide.
        issue(O_DIVU, 32'd1000, 32'd3, 0, 1'b0, 32'd0, "divu4");
        for (int i = 0; i < 5; i++) cyc(1'b0, O_NONE, 32'd0, 32'd0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst mid busy", {31'd0, mdu_busy_o}, 32'd0);
        #1;
        issue(O_MFLO, 32'd0, 32'd0, 0, 1'b1, 32'd0, "rst mid lo");
        issue(O_MFHI, 32'd0, 32'd0, 0, 1'b1, 32'd0, "rst mid hi");

        for (int i = 0; i < 4; i++) cyc(1'b0, O_NONE, 32'd0, 32'd0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
